// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM/WB stage bus: MEM-side inputs, register-file write and forwarding outputs
interface mem_wb_stage_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
);
  logic                      valid_in;
  logic                      stall;
  logic                      flush;
  logic                      reg_write_in;
  logic                      mem_to_reg_in;
  logic [7:0]                ALU_result_in;
  logic [7:0]                read_data;
  logic [REG_ADDR_WIDTH-1:0] rd_in;
  logic                      reg_write_out;
  logic [REG_ADDR_WIDTH-1:0] rd_out;
  logic [7:0]                write_back_data;
  logic                      fwd_valid;
  logic [REG_ADDR_WIDTH-1:0] fwd_rd;
  logic [7:0]                fwd_data;
  logic [COUNT_WIDTH-1:0]    retired_count;

  modport master (
    output valid_in, stall, flush, reg_write_in, mem_to_reg_in,
           ALU_result_in, read_data, rd_in,
    input  reg_write_out, rd_out, write_back_data,
           fwd_valid, fwd_rd, fwd_data, retired_count
  );

  modport slave (
    input  valid_in, stall, flush, reg_write_in, mem_to_reg_in,
           ALU_result_in, read_data, rd_in,
    output reg_write_out, rd_out, write_back_data,
           fwd_valid, fwd_rd, fwd_data, retired_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, write-back select, x0 suppression and retired counter
module mem_wb_stage #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
) (
  input logic          clock,
  input logic          reset,
  mem_wb_stage_if.slave bus
);
  logic                      r_valid;
  logic                      r_reg_write;
  logic                      r_mem_to_reg;
  logic [7:0]                r_alu;
  logic [7:0]                r_ld;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [COUNT_WIDTH-1:0]    r_count;

  logic                      w_retire;
  logic                      w_wen;
  logic [7:0]                w_wb_data;

  // The held instruction leaves whenever the register is overwritten, including by a flush.
  assign w_retire = r_valid & (bus.flush | ~bus.stall);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu        <= 8'h00;
      r_ld         <= 8'h00;
      r_rd         <= '0;
    end else if (bus.flush) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu        <= 8'h00;
      r_ld         <= 8'h00;
      r_rd         <= '0;
    end else if (!bus.stall) begin
      r_valid      <= bus.valid_in;
      r_reg_write  <= bus.reg_write_in;
      r_mem_to_reg <= bus.mem_to_reg_in;
      r_alu        <= bus.ALU_result_in;
      r_ld         <= bus.read_data;
      r_rd         <= bus.rd_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_retire && (r_count != {COUNT_WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign w_wb_data = r_mem_to_reg ? r_ld : r_alu;
  assign w_wen     = r_valid & r_reg_write & (r_rd != '0);

  assign bus.reg_write_out   = w_wen;
  assign bus.rd_out          = r_rd;
  assign bus.write_back_data = w_wb_data;
  assign bus.fwd_valid       = w_wen;
  assign bus.fwd_rd          = r_rd;
  assign bus.fwd_data        = w_wb_data;
  assign bus.retired_count   = r_count;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized and directed bench for mem_wb_stage against an instruction-level model
module tb_mem_wb_stage;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       valid_in, stall, flush, reg_write_in, mem_to_reg_in;
  logic [7:0] alu_in, ld_in;
  logic [4:0] rd_in;

  mem_wb_stage_if #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(16)) bus_b ();
  mem_wb_stage_if #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(4))  bus_s ();

  assign bus_b.valid_in = valid_in;           assign bus_s.valid_in = valid_in;
  assign bus_b.stall = stall;                 assign bus_s.stall = stall;
  assign bus_b.flush = flush;                 assign bus_s.flush = flush;
  assign bus_b.reg_write_in = reg_write_in;   assign bus_s.reg_write_in = reg_write_in;
  assign bus_b.mem_to_reg_in = mem_to_reg_in; assign bus_s.mem_to_reg_in = mem_to_reg_in;
  assign bus_b.ALU_result_in = alu_in;        assign bus_s.ALU_result_in = alu_in;
  assign bus_b.read_data = ld_in;             assign bus_s.read_data = ld_in;
  assign bus_b.rd_in = rd_in;                 assign bus_s.rd_in = rd_in;

  mem_wb_stage #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(16)) u_big (
    .clock(clock), .reset(reset), .bus(bus_b));
  mem_wb_stage #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(4)) u_small (
    .clock(clock), .reset(reset), .bus(bus_s));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: what sits in WB, the value it writes, and how many have left.
  logic       m_started = 1'b0;
  logic       m_valid, m_rw;
  logic [7:0] m_wb;
  logic [4:0] m_rd;
  int         m_cnt;

  always @(posedge clock) begin
    if (reset) begin
      m_started <= 1'b1;
      m_valid <= 1'b0; m_rw <= 1'b0; m_wb <= 8'h00; m_rd <= 5'd0; m_cnt <= 0;
    end else begin
      if (m_valid && (flush || !stall)) m_cnt <= m_cnt + 1;
      if (flush) begin
        m_valid <= 1'b0; m_rw <= 1'b0; m_wb <= 8'h00; m_rd <= 5'd0;
      end else if (!stall) begin
        m_valid <= valid_in;
        m_rw    <= reg_write_in;
        m_wb    <= mem_to_reg_in ? ld_in : alu_in;
        m_rd    <= rd_in;
      end
    end
  end

  always @(negedge clock) begin
    if (m_started) begin
      logic exp_we;
      exp_we = m_valid && m_rw && (m_rd != 5'd0);
      chk("cmp_we",     bus_b.reg_write_out,   exp_we);
      chk("cmp_fwdv",   bus_b.fwd_valid,       exp_we);
      chk("cmp_rd",     bus_b.rd_out,          m_rd);
      chk("cmp_fwdrd",  bus_b.fwd_rd,          m_rd);
      chk("cmp_wb",     bus_b.write_back_data, m_wb);
      chk("cmp_fwdd",   bus_b.fwd_data,        m_wb);
      chk("cmp_cnt16",  bus_b.retired_count,   (m_cnt > 65535) ? 65535 : m_cnt);
      chk("cmp_cnt4",   bus_s.retired_count,   (m_cnt > 15) ? 15 : m_cnt);
      chk("cmp_s_we",   bus_s.reg_write_out,   exp_we);
      chk("cmp_s_wb",   bus_s.write_back_data, m_wb);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic v, input logic rw, input logic m2r,
                      input logic [7:0] a, input logic [7:0] d, input logic [4:0] r);
    valid_in = v; reg_write_in = rw; mem_to_reg_in = m2r;
    alu_in = a; ld_in = d; rd_in = r;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    load(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_we",  bus_b.reg_write_out, 0);
    chk("rst_rd",  bus_b.rd_out, 0);
    chk("rst_wb",  bus_b.write_back_data, 0);
    chk("rst_fwd", {bus_b.fwd_valid, bus_b.fwd_rd, bus_b.fwd_data}, 0);
    chk("rst_cnt", bus_b.retired_count, 0);

    load(1'b1, 1'b1, 1'b0, 8'h3C, 8'h00, 5'd5); cyc();
    chk("alu_we", bus_b.reg_write_out, 1);
    chk("alu_rd", bus_b.rd_out, 5);
    chk("alu_wb", bus_b.write_back_data, 8'h3C);
    chk("alu_fwd", bus_b.fwd_data, 8'h3C);
    chk("alu_cnt0", bus_b.retired_count, 0);

    load(1'b1, 1'b1, 1'b1, 8'h10, 8'hA5, 5'd7); cyc();
    chk("alu_cnt1", bus_b.retired_count, 1);
    chk("ld_wb", bus_b.write_back_data, 8'hA5);
    chk("ld_rd", bus_b.rd_out, 7);

    load(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 5'd0); cyc();
    chk("x0_we", bus_b.reg_write_out, 0);
    chk("x0_fwdv", bus_b.fwd_valid, 0);
    chk("x0_cnt", bus_b.retired_count, 2);

    load(1'b1, 1'b1, 1'b0, 8'h42, 8'h00, 5'd3); cyc();
    chk("x0_exit_cnt", bus_b.retired_count, 3);
    stall = 1'b1;
    load(1'b1, 1'b1, 1'b0, 8'h99, 8'h00, 5'd9);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_wb", bus_b.write_back_data, 8'h42);
      chk("stall_rd", bus_b.rd_out, 3);
      chk("stall_cnt", bus_b.retired_count, 3);
    end
    stall = 1'b0; cyc();
    chk("unstall_wb", bus_b.write_back_data, 8'h99);
    chk("unstall_rd", bus_b.rd_out, 9);
    chk("unstall_cnt", bus_b.retired_count, 4);

    stall = 1'b1; flush = 1'b1; cyc();
    chk("flush_we", bus_b.reg_write_out, 0);
    chk("flush_cnt", bus_b.retired_count, 5);
    stall = 1'b0; flush = 1'b0;
    load(1'b1, 1'b1, 1'b0, 8'h77, 8'h00, 5'd4); cyc();
    chk("bubble_exit_cnt", bus_b.retired_count, 5);
    reset = 1'b1; flush = 1'b1; cyc();
    chk("rstfl_out", {bus_b.reg_write_out, bus_b.rd_out, bus_b.write_back_data,
                      bus_b.fwd_valid, bus_b.fwd_rd, bus_b.fwd_data}, 0);
    chk("rstfl_cnt", bus_b.retired_count, 0);
    reset = 1'b0; flush = 1'b0;

    load(1'b0, 1'b1, 1'b0, 8'h55, 8'h00, 5'd6); cyc();
    chk("bubble_we", bus_b.reg_write_out, 0);

    for (int i = 0; i < 20; i++) begin
      load(1'b1, 1'b1, 1'b0, 8'(i), 8'h00, 5'd1); cyc();
    end
    load(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0); cyc();
    chk("sat_small", bus_s.retired_count, 15);
    chk("sat_big", bus_b.retired_count, 20);
    cyc();
    chk("sat_hold", bus_s.retired_count, 15);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      load(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
      cyc();
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and write-back stage of the 8-bit RISC-V pipeline. Captures the memory stage's outputs (ALU result, load data, control bits, destination register) on each clock edge. Selects the write-back value and drives the register-file write port plus the forwarding path back to EX. Supports pipeline stall (hold), flush (bubble insertion) and x0 write suppression, and keeps a saturating retired-instruction counter.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, destination register index width
- COUNT_WIDTH, 16, retired-instruction counter width

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- valid_in  input  1  MEM stage holds a real instruction (0 = bubble)
- stall  input  1  hold the current MEM/WB contents
- flush  input  1  load a bubble instead of the MEM stage contents
- reg_write_in  input  1  instruction writes a register
- mem_to_reg_in  input  1  1 = write back load data, 0 = write back ALU result
- ALU_result_in  input  8  ALU result from MEM
- read_data  input  8  data-memory read data (combinational read, valid in the same cycle as ALU_result_in)
- rd_in  input  REG_ADDR_WIDTH  destination register index
- reg_write_out  output  1  register-file write enable
- rd_out  output  REG_ADDR_WIDTH  register-file write index
- write_back_data  output  8  register-file write data
- fwd_valid  output  1  forwarding source valid (equals reg_write_out)
- fwd_rd  output  REG_ADDR_WIDTH  forwarding destination index (equals rd_out)
- fwd_data  output  8  forwarding data (equals write_back_data)
- retired_count  output  COUNT_WIDTH  number of valid instructions retired, saturating

## Operation
- Internal registers: valid_q, reg_write_q, mem_to_reg_q, alu_q[7:0], ld_q[7:0], rd_q.
- Update priority at each rising edge: reset > flush > stall > load.
  - reset: all registers and retired_count cleared to 0.
  - flush: valid_q <= 0, reg_write_q <= 0. Data fields are don't-care; they are cleared to 0.
  - stall (flush=0): all registers hold.
  - load: valid_q <= valid_in, and every field is captured from its input.
- write_back_data = mem_to_reg_q ? ld_q : alu_q. This is combinational from the registers.
- reg_write_out = valid_q & reg_write_q & (rd_q != 0). A write to x0 is never issued.
- rd_out = rd_q.
- Forwarding outputs mirror the register-file outputs exactly.
- retired_count increments at an edge where valid_q = 1 and the register is not held (stall=0 or flush=1). An instruction whose rd is x0 still counts.
- retired_count saturates at all-ones and does not wrap.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N until the next update.
- Reset values: reg_write_out=0, rd_out=0, write_back_data=0, fwd_valid=0, fwd_rd=0, fwd_data=0, retired_count=0.
- Reset asserted mid-operation clears everything at the next edge, regardless of stall or flush.
- Stall: outputs stay constant for every stalled cycle.
  - reg_write_out may remain high across a stall; the repeated write of the same value is harmless.
  - The held instruction is counted once, when it leaves.
- Simultaneous stall and flush: flush wins, and the held instruction is retired (counted).
- valid_in=0 with reg_write_in=1 loads a bubble, so reg_write_out=0.
- No combinational path from any input to any output.

## Test plan
- Reset, then load ALU result with valid_in=1, reg_write_in=1, mem_to_reg_in=0, ALU_result_in=0x3C, rd_in=5.
  - Required next cycle: reg_write_out=1, rd_out=5, write_back_data=0x3C, fwd_data=0x3C.
  - Required one edge later: retired_count=1.
- Load data select: mem_to_reg_in=1, read_data=0xA5, ALU_result_in=0x10, rd_in=7.
  - Required: write_back_data=0xA5, rd_out=7.
- x0 suppression: valid_in=1, reg_write_in=1, rd_in=0, ALU_result_in=0xFF.
  - Required: reg_write_out=0 and fwd_valid=0.
  - Required: retired_count still increments on the instruction's exit.
- Stall hold: load 0x42 to rd=3, then assert stall for 3 cycles while the inputs change to 0x99 / rd=9.
  - Required: outputs stay at 0x42 / rd=3 throughout, and retired_count is unchanged during the stall.
  - Required: after stall drops, 0x99 / rd=9 appears and retired_count increases by exactly 1.
- Flush and priority:
  - Assert flush together with stall while WB holds a valid instruction. Required: next cycle reg_write_out=0, and retired_count increases by 1.
  - Assert reset together with flush. Required: all outputs 0.
- Counter saturation: with COUNT_WIDTH=4, retire 20 valid instructions.
  - Required: retired_count reaches 15 and stays at 15.
